// File: rtl/periph_idx_demux.sv
// periph_idx_demux: steers one master request to an indexed peripheral port and returns responses in issue order
module periph_idx_demux #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int N_OUPS          = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         data_req_i,
  input  logic [ADDR_WIDTH-1:0]        data_add_i,
  input  logic                         data_wen_i,
  input  logic [DATA_WIDTH-1:0]        data_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]      data_be_i,
  input  logic [$clog2(N_OUPS):0]      pe_idx_i,
  output logic                         data_gnt_o,
  output logic                         data_r_valid_o,
  output logic [DATA_WIDTH-1:0]        data_r_rdata_o,
  output logic                         data_r_opc_o,
  output logic [N_OUPS-1:0]            per_req_o,
  output logic [ADDR_WIDTH-1:0]        per_add_o,
  output logic                         per_wen_o,
  output logic [DATA_WIDTH-1:0]        per_wdata_o,
  output logic [DATA_WIDTH/8-1:0]      per_be_o,
  input  logic [N_OUPS-1:0]            per_gnt_i,
  input  logic [N_OUPS-1:0]            per_r_valid_i,
  input  logic [N_OUPS*DATA_WIDTH-1:0] per_r_rdata_i,
  input  logic [N_OUPS-1:0]            per_r_opc_i,
  output logic                         proto_err_o
);
  localparam int SW = $clog2(N_OUPS);
  localparam int IW = SW + 1;
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hBADACCE5);

  logic [SW-1:0]     fifo_idx [MAX_OUTSTANDING];
  logic              fifo_err [MAX_OUTSTANDING];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0]     count, count_n;
  logic              full, empty, idx_ok, push, pop;
  logic              head_err, resp_ok, err_q, err_n;
  logic [SW-1:0]     sel, head_sel;
  logic [N_OUPS-1:0] expect_rv;

  // Request path: zero-latency steering, blocked entirely while the index FIFO is full
  always_comb begin
    full       = count == MAX_CNT;
    empty      = count == '0;
    idx_ok     = pe_idx_i < IW'(N_OUPS);
    sel        = pe_idx_i[SW-1:0];
    per_req_o  = (rst_ni && !full && idx_ok && data_req_i) ? N_OUPS'(1) << sel : '0;
    data_gnt_o = rst_ni && !full && (idx_ok ? per_gnt_i[sel] : data_req_i);
    per_add_o  = rst_ni ? data_add_i : '0;
    per_wen_o  = rst_ni && data_wen_i;
    per_wdata_o = rst_ni ? data_wdata_i : '0;
    per_be_o   = rst_ni ? data_be_i : '0;
    push       = data_req_i && data_gnt_o;
  end

  // Response path: head entry selects the returning port; error heads answer from the local register
  always_comb begin
    head_sel       = fifo_idx[rd_ptr];
    head_err       = fifo_err[rd_ptr];
    resp_ok        = !empty && !head_err && per_r_valid_i[head_sel];
    data_r_valid_o = err_q || resp_ok;
    data_r_rdata_o = err_q ? ERR_DATA : resp_ok ? per_r_rdata_i[head_sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    data_r_opc_o   = err_q || (resp_ok && per_r_opc_i[head_sel]);
    pop            = data_r_valid_o;
    expect_rv      = (!empty && !head_err) ? N_OUPS'(1) << head_sel : '0;
  end

  // Next FIFO state; err_n looks ahead at the head after this edge, including a same-cycle push into it
  always_comb begin
    count_n  = count + CW'(push) - CW'(pop);
    wr_ptr_n = push ? (wr_ptr == LAST ? '0 : wr_ptr + 1'b1) : wr_ptr;
    rd_ptr_n = pop ? (rd_ptr == LAST ? '0 : rd_ptr + 1'b1) : rd_ptr;
    err_n    = (count_n != '0) && ((push && rd_ptr_n == wr_ptr) ? !idx_ok : fifo_err[rd_ptr_n]);
  end

  // Control state: occupancy, pointers, local error response and sticky protocol error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      err_q       <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      count       <= count_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      err_q       <= err_n;
      proto_err_o <= proto_err_o | (|(per_r_valid_i & ~expect_rv));
    end
  end

  // Index storage needs no reset: entries are only read while counted as occupied
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_idx[wr_ptr] <= sel;
      fifo_err[wr_ptr] <= !idx_ok;
    end
  end
endmodule

// File: tb/tb_periph_idx_demux.sv
// tb_periph_idx_demux: directed vector table plus hand sequences for reset, protocol error and FIFO wrap
module tb_periph_idx_demux;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 8;
  localparam int MO = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            data_req_i = 1'b0;
  logic [AW-1:0]   data_add_i = 32'h4000_1000;
  logic            data_wen_i = 1'b1;
  logic [DW-1:0]   data_wdata_i = 32'h0;
  logic [DW/8-1:0] data_be_i = 4'hF;
  logic [3:0]      pe_idx_i = 4'd0;
  logic            data_gnt_o, data_r_valid_o, data_r_opc_o, per_wen_o, proto_err_o;
  logic [DW-1:0]   data_r_rdata_o, per_wdata_o;
  logic [N-1:0]    per_req_o;
  logic [AW-1:0]   per_add_o;
  logic [DW/8-1:0] per_be_o;
  logic [N-1:0]    per_gnt_i = '0;
  logic [N-1:0]    per_r_valid_i = '0;
  logic [N*DW-1:0] per_r_rdata_i = '0;
  logic [N-1:0]    per_r_opc_i = '0;

  int n_checks = 0;
  int n_fail = 0;

  periph_idx_demux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_OUPS(N), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(data_req_i), .data_add_i(data_add_i),
    .data_wen_i(data_wen_i), .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
    .pe_idx_i(pe_idx_i), .data_gnt_o(data_gnt_o), .data_r_valid_o(data_r_valid_o),
    .data_r_rdata_o(data_r_rdata_o), .data_r_opc_o(data_r_opc_o), .per_req_o(per_req_o),
    .per_add_o(per_add_o), .per_wen_o(per_wen_o), .per_wdata_o(per_wdata_o),
    .per_be_o(per_be_o), .per_gnt_i(per_gnt_i), .per_r_valid_i(per_r_valid_i),
    .per_r_rdata_i(per_r_rdata_i), .per_r_opc_i(per_r_opc_i), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        req;
    logic [3:0]  idx;
    logic [7:0]  gnt;
    logic [7:0]  rv;
    logic [7:0]  opc;
    logic [31:0] rd;
    logic        e_gnt;
    logic [7:0]  e_req;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_opc;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [3:0] idx, input logic [7:0] gnt,
                       input logic [7:0] rv, input logic [7:0] opc, input logic [31:0] rd);
    data_req_i = req;
    pe_idx_i = idx;
    per_gnt_i = gnt;
    per_r_valid_i = rv;
    per_r_opc_i = opc;
    for (int k = 0; k < N; k++) per_r_rdata_i[k*DW +: DW] = rv[k] ? rd : (32'hDEAD0000 | k);
  endtask

  task automatic cycle;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string tag, input logic gnt, input logic [7:0] req,
                           input logic rv, input logic [31:0] rd, input logic opc);
    #2;
    check({tag, ".gnt"}, 64'(data_gnt_o), 64'(gnt));
    check({tag, ".per_req"}, 64'(per_req_o), 64'(req));
    check({tag, ".r_valid"}, 64'(data_r_valid_o), 64'(rv));
    check({tag, ".rdata"}, 64'(data_r_rdata_o), 64'(rd));
    check({tag, ".opc"}, 64'(data_r_opc_o), 64'(opc));
  endtask

  initial begin
    logic [3:0] q[$];
    logic [3:0] nidx;
    logic [7:0] m;
    vecs[0]  = '{1'b1, 4'd3,  8'h08, 8'h00, 8'h00, 32'h0,        1'b1, 8'h08, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 4'd3,  8'h00, 8'h08, 8'h00, 32'h1234,     1'b0, 8'h00, 1'b1, 32'h1234,     1'b0};
    vecs[2]  = '{1'b1, 4'd1,  8'h02, 8'h00, 8'h00, 32'h0,        1'b1, 8'h02, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 4'd2,  8'h04, 8'h00, 8'h00, 32'h0,        1'b1, 8'h04, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{1'b1, 4'd1,  8'h02, 8'h00, 8'h00, 32'h0,        1'b1, 8'h02, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 4'd5,  8'h20, 8'h00, 8'h00, 32'h0,        1'b1, 8'h20, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 4'd3,  8'hFF, 8'h00, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 4'd3,  8'hFF, 8'h02, 8'h00, 32'hAAAA0001, 1'b0, 8'h00, 1'b1, 32'hAAAA0001, 1'b0};
    vecs[8]  = '{1'b0, 4'd0,  8'h00, 8'h04, 8'h04, 32'hBBBB0002, 1'b0, 8'h00, 1'b1, 32'hBBBB0002, 1'b1};
    vecs[9]  = '{1'b0, 4'd0,  8'h00, 8'h02, 8'h00, 32'hCCCC0003, 1'b0, 8'h00, 1'b1, 32'hCCCC0003, 1'b0};
    vecs[10] = '{1'b1, 4'd3,  8'h08, 8'h20, 8'h00, 32'hDDDD0005, 1'b1, 8'h08, 1'b1, 32'hDDDD0005, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  8'h00, 8'h08, 8'h00, 32'h0EEE0003, 1'b0, 8'h00, 1'b1, 32'h0EEE0003, 1'b0};
    vecs[12] = '{1'b1, 4'd8,  8'hFF, 8'h00, 8'h00, 32'h0,        1'b1, 8'h00, 1'b0, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 4'd0,  8'h00, 8'h00, 8'h00, 32'h0,        1'b0, 8'h00, 1'b1, 32'hBADACCE5, 1'b1};
    vecs[14] = '{1'b0, 4'd9,  8'h00, 8'h00, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 32'h0,        1'b0};
    vecs[15] = '{1'b1, 4'd8,  8'h00, 8'h00, 8'h00, 32'h0,        1'b1, 8'h00, 1'b0, 32'h0,        1'b0};
    vecs[16] = '{1'b1, 4'd15, 8'h00, 8'h00, 8'h00, 32'h0,        1'b1, 8'h00, 1'b1, 32'hBADACCE5, 1'b1};
    vecs[17] = '{1'b0, 4'd0,  8'h00, 8'h00, 8'h00, 32'h0,        1'b0, 8'h00, 1'b1, 32'hBADACCE5, 1'b1};
    vecs[18] = '{1'b0, 4'd0,  8'h00, 8'h00, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 32'h0,        1'b0};

    drive(1'b1, 4'd3, 8'h08, 8'h00, 8'h00, 32'h0);
    check_out("reset", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    check("reset.proto_err", 64'(proto_err_o), 64'h0);
    cycle;
    cycle;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 8'h00, 32'h0);
    rst_ni = 1'b1;
    #1;
    check("per_add", 64'(per_add_o), 64'h4000_1000);
    cycle;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].req, vecs[i].idx, vecs[i].gnt, vecs[i].rv, vecs[i].opc, vecs[i].rd);
      check_out($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_req, vecs[i].e_rv, vecs[i].e_rd, vecs[i].e_opc);
      cycle;
    end
    check("table.proto_err", 64'(proto_err_o), 64'h0);

    drive(1'b1, 4'd2, 8'h04, 8'h00, 8'h00, 32'h0);
    check_out("perr.push", 1'b1, 8'h04, 1'b0, 32'h0, 1'b0);
    cycle;
    drive(1'b0, 4'd0, 8'h00, 8'h10, 8'h00, 32'h5555);
    check_out("perr.wrong_port", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    check("perr.before", 64'(proto_err_o), 64'h0);
    cycle;
    check("perr.set", 64'(proto_err_o), 64'h1);
    drive(1'b0, 4'd0, 8'h00, 8'h00, 8'h00, 32'h0);
    cycle;
    check("perr.sticky", 64'(proto_err_o), 64'h1);
    drive(1'b0, 4'd0, 8'h00, 8'h04, 8'h00, 32'h6666);
    check_out("perr.head_resp", 1'b0, 8'h00, 1'b1, 32'h6666, 1'b0);
    cycle;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 8'h00, 32'h0);
    check_out("perr.idle", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    check("perr.still", 64'(proto_err_o), 64'h1);
    cycle;

    drive(1'b1, 4'd1, 8'h02, 8'h00, 8'h00, 32'h0);
    cycle;
    drive(1'b1, 4'd2, 8'h04, 8'h00, 8'h00, 32'h0);
    cycle;
    drive(1'b1, 4'd3, 8'h08, 8'h02, 8'h00, 32'h7777);
    check_out("rst.pre", 1'b1, 8'h08, 1'b1, 32'h7777, 1'b0);
    rst_ni = 1'b0;
    check_out("rst.mid", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    check("rst.proto_err", 64'(proto_err_o), 64'h0);
    cycle;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 8'h00, 32'h0);
    rst_ni = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 8'h02, 8'h00, 32'h8888);
    check_out("rst.late_resp", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    cycle;
    check("rst.late_perr", 64'(proto_err_o), 64'h1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i), 8'(1) << i, 8'h00, 8'h00, 32'h0);
      check_out($sformatf("rst.fill%0d", i), 1'b1, 8'(1) << i, 1'b0, 32'h0, 1'b0);
      cycle;
    end
    drive(1'b1, 4'd4, 8'h10, 8'h00, 8'h00, 32'h0);
    check_out("rst.full", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'd0, 8'h00, 8'(1) << i, 8'h00, 32'h9000 + 32'(i));
      check_out($sformatf("rst.drain%0d", i), 1'b0, 8'h00, 1'b1, 32'h9000 + 32'(i), 1'b0);
      cycle;
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00, 8'h00, 32'h0);
    rst_ni = 1'b0;
    cycle;
    rst_ni = 1'b1;
    cycle;
    check("rst.cleared", 64'(proto_err_o), 64'h0);

    drive(1'b1, 4'd0, 8'h01, 8'h00, 8'h00, 32'h0);
    cycle;
    drive(1'b1, 4'd1, 8'h02, 8'h00, 8'h00, 32'h0);
    cycle;
    q.push_back(4'd0);
    q.push_back(4'd1);
    for (int i = 0; i < 14; i++) begin
      nidx = 4'((i * 5 + 6) % 8);
      m = 8'(1) << nidx;
      drive(1'b1, nidx, m, 8'(1) << q[0], 8'h00, 32'hC0DE0000 + 32'(i));
      check_out($sformatf("wrap%0d", i), 1'b1, m, 1'b1, 32'hC0DE0000 + 32'(i), 1'b0);
      cycle;
      void'(q.pop_front());
      q.push_back(nidx);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'd0, 8'h00, 8'(1) << q[0], 8'h00, 32'hF00D0000 + 32'(i));
      check_out($sformatf("wrap.drain%0d", i), 1'b0, 8'h00, 1'b1, 32'hF00D0000 + 32'(i), 1'b0);
      cycle;
      void'(q.pop_front());
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00, 8'h00, 32'h0);
    check_out("wrap.empty", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    check("wrap.proto_err", 64'(proto_err_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
